// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by fetch and decode.
package riscv_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/dualport_bus.sv
// dualport_bus: read/write memory port with request/grant handshake.
interface dualport_bus;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data,
                    input  rd_gnt, rd_data);
    modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
                    output rd_gnt, rd_data);
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry valid/pc/instr holding buffer with load/hold/clear.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [31:0]  pc_i,
    input  logic [31:0]  instr_i,
    output fetch_entry_t entry_o
);
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = clear_i ? '0 :
                  load_i  ? '{valid: 1'b1, pc: pc_i, instr: instr_i} : entry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entry_q <= '0;
        else        entry_q <= entry_d;
    end

    assign entry_o = entry_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC/request logic for the instruction ROM and valid/pc/instr delivery to decode.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    dualport_bus.master instr_master,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o
);
    logic [31:0]  pc_q, pc_d, pend_pc_q, pend_pc_d;
    logic         pending_q, pending_d;
    logic         rd_req, accept, buf_load, buf_clear;
    logic [31:0]  rd_addr;
    fetch_entry_t buf_e;

    // Requests are gated by rst_n so nothing is issued while reset is held.
    assign rd_req  = rst_n & (redirect_i | ~(stall_i & (pending_q | buf_e.valid)));
    assign rd_addr = (rst_n & redirect_i) ? {redirect_pc_i[31:2], 2'b00} : pc_q;

    assign instr_master.rd_req  = rd_req;
    assign instr_master.rd_addr = rd_addr;
    assign instr_master.wr_req  = 1'b0;
    assign instr_master.wr_addr = '0;
    assign instr_master.wr_data = '0;

    always_comb begin
        accept     = rd_req & instr_master.rd_gnt;
        pc_d       = accept ? rd_addr + 32'd4 : pc_q;
        pend_pc_d  = accept ? rd_addr : pend_pc_q;
        pending_d  = accept;
        id_valid_o = ~redirect_i & (buf_e.valid | pending_q);
        id_pc_o    = buf_e.valid ? buf_e.pc : pending_q ? pend_pc_q : '0;
        id_instr_o = ~id_valid_o  ? NOP_INSTR :
                     buf_e.valid  ? buf_e.instr : instr_master.rd_data;
        buf_load   = stall_i & id_valid_o & ~buf_e.valid;
        buf_clear  = redirect_i | ~stall_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            pending_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pending_q <= pending_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pc_i    (pend_pc_q),
        .instr_i (instr_master.rd_data),
        .entry_o (buf_e)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch sequencing, stall/skid, redirect and grant backpressure.
module tb_instr_fetch;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        gnt = 1'b1;
    logic [31:0] redirect_pc = '0;
    logic [31:0] rom_q = '0;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    int          total = 0;
    int          bad = 0;

    logic [31:0] rom [22] = '{
        32'h00708093, 32'h00710113, 32'h00110863, 32'h002081b3,
        32'h00720213, 32'h00128293, 32'h00230313, 32'h00338393,
        32'h00440413, 32'h00548493, 32'h00650513, 32'h00758593,
        32'h00860613, 32'h00968693, 32'h00a70713, 32'h00b78793,
        32'h00c80813, 32'h00d88893, 32'hff9ff06f, 32'h00000073,
        32'h00100073, 32'h0000006f
    };

    always #5 clk = ~clk;

    dualport_bus bus ();
    assign bus.rd_gnt  = gnt;
    assign bus.rd_data = rom_q;

    // Registered ROM: out-of-range words read as 0.
    always @(posedge clk) begin
        if (bus.rd_req && bus.rd_gnt)
            rom_q <= (bus.rd_addr < 32'd88) ? rom[bus.rd_addr[6:2]] : 32'h0;
    end

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_master  (bus.master),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .id_valid_o    (id_valid),
        .id_pc_o       (id_pc),
        .id_instr_o    (id_instr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] rp, input logic g);
        @(negedge clk);
        stall = s;
        redirect = r;
        redirect_pc = rp;
        gnt = g;
        #1;
    endtask

    task automatic out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, ".valid"}, 32'(id_valid), 32'(v));
        check({tag, ".pc"}, id_pc, pc);
        check({tag, ".instr"}, id_instr, ins);
    endtask

    initial begin
        #1;
        check("rst.rd_req", 32'(bus.rd_req), 32'd0);
        check("rst.rd_addr", bus.rd_addr, 32'h0);
        out("rst", 1'b0, 32'h0, NOP_INSTR);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first.rd_req", 32'(bus.rd_req), 32'd1);
        check("first.rd_addr", bus.rd_addr, 32'h0);
        check("first.valid", 32'(id_valid), 32'd0);
        cyc(0, 0, 0, 1);
        out("seq0", 1'b1, 32'h0, 32'h00708093);
        check("seq0.rd_addr", bus.rd_addr, 32'h4);
        cyc(0, 0, 0, 1);
        out("seq1", 1'b1, 32'h4, 32'h00710113);
        check("seq1.rd_addr", bus.rd_addr, 32'h8);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 1);
            out("stall", 1'b1, 32'h8, 32'h00110863);
            if (i > 0) check("stall.rd_req", 32'(bus.rd_req), 32'd0);
        end
        cyc(0, 0, 0, 1);
        out("release", 1'b1, 32'h8, 32'h00110863);
        check("release.rd_req", 32'(bus.rd_req), 32'd1);
        check("release.rd_addr", bus.rd_addr, 32'hC);
        cyc(0, 0, 0, 1);
        out("after", 1'b1, 32'hC, 32'h002081b3);
        cyc(0, 0, 0, 1);
        out("seq4", 1'b1, 32'h10, 32'h00720213);
        cyc(0, 0, 0, 1);
        out("seq5", 1'b1, 32'h14, 32'h00128293);
        cyc(0, 1, 32'h10, 1);
        out("redir", 1'b0, 32'h18, NOP_INSTR);
        check("redir.rd_addr", bus.rd_addr, 32'h10);
        cyc(0, 0, 0, 1);
        out("redir.tgt", 1'b1, 32'h10, 32'h00720213);
        cyc(1, 0, 0, 1);
        out("fill", 1'b1, 32'h14, 32'h00128293);
        cyc(1, 0, 0, 1);
        out("held", 1'b1, 32'h14, 32'h00128293);
        check("held.rd_req", 32'(bus.rd_req), 32'd0);
        cyc(1, 1, 32'h48, 1);
        check("skidredir.valid", 32'(id_valid), 32'd0);
        check("skidredir.rd_req", 32'(bus.rd_req), 32'd1);
        check("skidredir.rd_addr", bus.rd_addr, 32'h48);
        cyc(0, 0, 0, 1);
        out("skidredir.tgt", 1'b1, 32'h48, 32'hff9ff06f);
        cyc(0, 1, 32'h58, 1);
        check("oor.rd_addr", bus.rd_addr, 32'h58);
        cyc(0, 0, 0, 1);
        out("oor", 1'b1, 32'h58, 32'h0);
        cyc(0, 1, 32'h13, 1);
        check("mis.rd_addr", bus.rd_addr, 32'h10);
        cyc(0, 0, 0, 1);
        out("mis", 1'b1, 32'h10, 32'h00720213);
        cyc(0, 0, 0, 0);
        out("nogn0", 1'b1, 32'h14, 32'h00128293);
        check("nogn0.rd_addr", bus.rd_addr, 32'h18);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0);
            check("nogn.valid", 32'(id_valid), 32'd0);
            check("nogn.rd_addr", bus.rd_addr, 32'h18);
        end
        cyc(0, 0, 0, 1);
        check("gnt.valid", 32'(id_valid), 32'd0);
        check("gnt.rd_addr", bus.rd_addr, 32'h18);
        cyc(0, 0, 0, 1);
        out("gnt.out", 1'b1, 32'h18, 32'h00230313);
        cyc(0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        out("midrst", 1'b0, 32'h0, NOP_INSTR);
        check("midrst.rd_req", 32'(bus.rd_req), 32'd0);
        check("midrst.rd_addr", bus.rd_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerst.valid", 32'(id_valid), 32'd0);
        check("rerst.rd_addr", bus.rd_addr, 32'h0);
        cyc(0, 0, 0, 1);
        out("rerst.out", 1'b1, 32'h0, 32'h00708093);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RISC-V core. Acts as master on a `dualport_bus` to the instruction ROM, maintains the PC, and applies stalls from decode and redirects from branch/jump resolution. Delivers a valid/pc/instr triple to the decode stage, with a one-entry skid buffer so stalls never lose a ROM response.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `instr_master`  `dualport_bus.master`: `rd_req`, `rd_addr[31:0]`, `rd_gnt`, `rd_data[31:0]` used; `wr_req`, `wr_addr`, `wr_data` tied to 0.
- `stall_i`  in  1: decode cannot accept this cycle.
- `redirect_i`  in  1: branch/jump taken; current fetch stream is wrong-path.
- `redirect_pc_i`  in  32: target address; bits [1:0] ignored.
- `id_valid_o`  out  1: `id_pc_o`/`id_instr_o` hold a real instruction.
- `id_pc_o`  out  32: address of `id_instr_o`.
- `id_instr_o`  out  32: instruction word; NOP 32'h0000_0013 when `id_valid_o`=0.

## Operation
- State: `pc_q` (next fetch address), `pending` and `pend_pc` (request accepted last cycle), `buf_valid`, `buf_pc` and `buf_instr` (skid entry).
- Invariant: `pending` and `buf_valid` are never both 1.
- Request: `rd_req` = `redirect_i` | ~(`stall_i` & (`pending` | `buf_valid`)).
- Address: `rd_addr` = `redirect_i` ? {`redirect_pc_i`[31:2],2'b00} : `pc_q`.
- Acceptance: a request is accepted when `rd_req` & `rd_gnt`. On acceptance, `pend_pc` <= `rd_addr` and `pc_q` <= `rd_addr`+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - `rd_gnt`=0: no state change; `rd_addr` stays stable and the request retries.
  - A redirect during a retry replaces the address.
- Output select:
  - `buf_valid`=1: outputs show the skid entry.
  - Otherwise, `pending`=1: outputs show `rd_data` and `pend_pc`.
  - Otherwise: `id_valid_o`=0.
- Redirect masking: `id_valid_o` is forced to 0 whenever `redirect_i`=1.
- Skid fill: when `stall_i`=1, `id_valid_o`=1 and `buf_valid`=0, capture `rd_data`/`pend_pc` into the skid entry. While stalled with `buf_valid`=1 the entry is held.
- Skid drain: when `stall_i`=0 the output is consumed and `buf_valid` <= 0.
- Redirect: `redirect_i` has priority over `stall_i`. It clears `buf_valid`, discards the pending response and issues the fetch at the target in the same cycle.
- ROM data is passed through unmodified. A 0 word returned for out-of-range addresses is presented with `id_valid_o`=1; decode is responsible for it.

## Timing
- Reset values:
  - `rd_req`=0 and `rd_addr`=`RESET_PC` while `rst_n`=0.
  - `pc_q`=`RESET_PC`; `pending`=0 and `buf_valid`=0.
  - `id_valid_o`=0, `id_pc_o`=0, `id_instr_o`=NOP.
- First request: issued in the first cycle with `rst_n`=1.
- Latency: a request accepted in cycle t appears at the outputs in cycle t+1 (ROM read is registered).
- Throughput: one instruction per cycle with `stall_i`=0.
- Redirect penalty: redirect in cycle t gives the target instruction at t+1, with no wrong-path valid output in t or t+1.
- Stall entry: one additional request may already be pending; it lands in the skid entry and `rd_req` drops from the next cycle.
- Stall release: in cycle r, the held instruction is output and a new request is issued. Output continues at r+1 with no bubble.
- Reset mid-operation: all state returns to its reset values immediately; an in-flight ROM response is ignored.

## Structure
- `riscv_pkg` holds `NOP_INSTR` (32'h0000_0013) and the default `RESET_PC`; decode shares both.
- Sub-module `fetch_skid_buf` holds the one-entry valid/pc/instr buffer with load/hold/clear controls. PC and request logic stay in `instr_fetch`.

## Test plan
- Reset release with `stall_i`=0 against the standard ROM:
  - `rd_addr` sequence is 0, 4, 8.
  - Cycle after the first request: `id_pc_o`=0, `id_instr_o`=32'h00708093.
  - Next cycle: `id_pc_o`=4, `id_instr_o`=32'h00710113.
- Stall while `id_pc_o`=8:
  - Outputs hold `id_pc_o`=8 / 32'h00110863 for 5 cycles.
  - `rd_req`=0 after one cycle.
  - After release: pc 0xC / 32'h002081b3 with no bubble.
- `redirect_i`=1 with `redirect_pc_i`=0x10:
  - `id_valid_o`=0 in the redirect cycle.
  - Next cycle: `id_pc_o`=0x10, `id_instr_o`=32'h00720213.
- Redirect to 0x48 while stalled with the skid entry full: buffer dropped; next cycle `id_pc_o`=0x48, `id_instr_o`=32'hff9ff06f.
- Redirect to 0x58 (index 22, out of range): `id_valid_o`=1, `id_instr_o`=0. Misaligned target 0x13: `rd_addr`=0x10.
- Stub slave withholding `rd_gnt` for 3 cycles: `rd_addr` stable, no `id_valid_o`, no PC advance until the grant.
